cv32e40p_x_copro_adapter: RTL and testbench

Coprocessor-side end of the CORE-V-XIF link. It responds to issue requests offloaded by the cv32e40p dispatcher and buffers accepted instructions until the core commits or kills them. Committed instructions are executed in order on a generic accelerator datapath, and each result is returned on the XIF result channel. It sits between the core's X-interface and a single-issue custom functional unit.

---
 rtl/cv32e40p_x_copro_adapter.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_cv32e40p_x_copro_adapter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_copro_adapter.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_x_copro_adapter
// Brief    : CORE-V-XIF coprocessor adapter. It buffers offloaded instructions
//            until commit or kill, then runs them in order on one accelerator.
//            Macro X_COPRO_RS3_EN enables the third source operand.
// Revision : 1.0
// ============================================================================
module cv32e40p_x_copro_adapter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4,
    parameter logic [6:0]  OPCODE   = 7'h0B
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                x_issue_valid_i,
    output logic                x_issue_ready_o,
    input  logic [31:0]         x_issue_req_instr_i,
    input  logic [ID_WIDTH-1:0] x_issue_req_id_i,
    input  logic [95:0]         x_issue_req_rs_i,
    input  logic [2:0]          x_issue_req_rs_valid_i,
    output logic                x_issue_resp_accept_o,
    output logic                x_issue_resp_writeback_o,
    output logic                x_issue_resp_loadstore_o,
    input  logic                x_commit_valid_i,
    input  logic [ID_WIDTH-1:0] x_commit_id_i,
    input  logic                x_commit_kill_i,
    output logic                acc_valid_o,
    input  logic                acc_ready_i,
    output logic [31:0]         acc_instr_o,
    output logic [95:0]         acc_rs_o,
    input  logic                acc_resp_valid_i,
    input  logic [31:0]         acc_resp_data_i,
    output logic                x_result_valid_o,
    input  logic                x_result_ready_i,
    output logic [ID_WIDTH-1:0] x_result_id_o,
    output logic [31:0]         x_result_data_o,
    output logic [4:0]          x_result_rd_o,
    output logic                x_result_we_o,
    output logic                busy_o
);

    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_EXEC   = 2'b01;
    localparam logic [1:0] ST_WAIT   = 2'b10;
    localparam logic [1:0] ST_RESULT = 2'b11;

    // In-flight buffer
    logic [DEPTH-1:0]    ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0]    ent_cmt_q,   ent_cmt_d;
    logic [DEPTH-1:0]    ent_kill_q,  ent_kill_d;
    logic [ID_WIDTH-1:0] ent_id_q    [DEPTH];
    logic [ID_WIDTH-1:0] ent_id_d    [DEPTH];
    logic [31:0]         ent_instr_q [DEPTH];
    logic [31:0]         ent_instr_d [DEPTH];
    logic [31:0]         ent_rs0_q   [DEPTH];
    logic [31:0]         ent_rs0_d   [DEPTH];
    logic [31:0]         ent_rs1_q   [DEPTH];
    logic [31:0]         ent_rs1_d   [DEPTH];
`ifdef X_COPRO_RS3_EN
    logic [31:0]         ent_rs2_q   [DEPTH];
    logic [31:0]         ent_rs2_d   [DEPTH];
`endif

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [PTR_W:0]      count_q, count_d;

    // Operation register and FSM
    logic [1:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] op_id_q, op_id_d;
    logic [31:0]         op_instr_q, op_instr_d;
    logic [31:0]         op_rs0_q, op_rs0_d;
    logic [31:0]         op_rs1_q, op_rs1_d;
`ifdef X_COPRO_RS3_EN
    logic [31:0]         op_rs2_q, op_rs2_d;
`endif
    logic [31:0]         res_data_q, res_data_d;

    logic                full;
    logic                issue_ready;
    logic                opcode_match;
    logic                alloc;
    logic [DEPTH-1:0]    commit_hit;
    logic                alloc_commit_hit;
    logic                head_live;
    logic                pop_exec;
    logic                pop_drop;
    logic                retire;

`ifndef X_COPRO_RS3_EN
    logic unused_rs2;
    assign unused_rs2 = ^{x_issue_req_rs_valid_i[2], x_issue_req_rs_i[95:64]};
`endif

    // Issue handshake
    always_comb begin
        full = (count_q == FULL_CNT);
`ifdef X_COPRO_RS3_EN
        issue_ready = ~full & (&x_issue_req_rs_valid_i);
`else
        issue_ready = ~full & x_issue_req_rs_valid_i[0] & x_issue_req_rs_valid_i[1];
`endif
        opcode_match = (x_issue_req_instr_i[6:0] == OPCODE);
        alloc        = x_issue_valid_i & issue_ready & opcode_match;
    end

    // Commit lookup; the entry being allocated this cycle is matched too
    always_comb begin
        commit_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            commit_hit[i] = x_commit_valid_i & ent_valid_q[i] & ~ent_cmt_q[i]
                          & ~ent_kill_q[i] & (ent_id_q[i] == x_commit_id_i);
        end
        alloc_commit_hit = x_commit_valid_i & alloc & ~(|commit_hit)
                         & (x_issue_req_id_i == x_commit_id_i);
    end

    always_comb begin
        head_live = ent_valid_q[head_q];
        pop_drop  = head_live & ent_kill_q[head_q];
        pop_exec  = head_live & ent_cmt_q[head_q] & (state_q == ST_IDLE);
        retire    = pop_drop | pop_exec;
    end

    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_cmt_d   = ent_cmt_q;
        ent_kill_d  = ent_kill_q;
        ent_id_d    = ent_id_q;
        ent_instr_d = ent_instr_q;
        ent_rs0_d   = ent_rs0_q;
        ent_rs1_d   = ent_rs1_q;
`ifdef X_COPRO_RS3_EN
        ent_rs2_d   = ent_rs2_q;
`endif
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (commit_hit[i]) begin
                ent_cmt_d[i]  = ~x_commit_kill_i;
                ent_kill_d[i] = x_commit_kill_i;
            end
        end

        if (retire) begin
            ent_valid_d[head_q] = 1'b0;
            ent_cmt_d[head_q]   = 1'b0;
            ent_kill_d[head_q]  = 1'b0;
            head_d              = head_q + PTR_ONE;
        end

        // Tail never aliases a retiring head: that needs count 0 or DEPTH
        if (alloc) begin
            ent_valid_d[tail_q] = 1'b1;
            ent_cmt_d[tail_q]   = alloc_commit_hit & ~x_commit_kill_i;
            ent_kill_d[tail_q]  = alloc_commit_hit & x_commit_kill_i;
            ent_id_d[tail_q]    = x_issue_req_id_i;
            ent_instr_d[tail_q] = x_issue_req_instr_i;
            ent_rs0_d[tail_q]   = x_issue_req_rs_i[31:0];
            ent_rs1_d[tail_q]   = x_issue_req_rs_i[63:32];
`ifdef X_COPRO_RS3_EN
            ent_rs2_d[tail_q]   = x_issue_req_rs_i[95:64];
`endif
            tail_d              = tail_q + PTR_ONE;
        end

        case ({alloc, retire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_id_d    = op_id_q;
        op_instr_d = op_instr_q;
        op_rs0_d   = op_rs0_q;
        op_rs1_d   = op_rs1_q;
`ifdef X_COPRO_RS3_EN
        op_rs2_d   = op_rs2_q;
`endif
        res_data_d = res_data_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_exec) begin
                    state_d    = ST_EXEC;
                    op_id_d    = ent_id_q[head_q];
                    op_instr_d = ent_instr_q[head_q];
                    op_rs0_d   = ent_rs0_q[head_q];
                    op_rs1_d   = ent_rs1_q[head_q];
`ifdef X_COPRO_RS3_EN
                    op_rs2_d   = ent_rs2_q[head_q];
`endif
                end
            end
            ST_EXEC: begin
                if (acc_ready_i) begin
                    if (acc_resp_valid_i) begin
                        res_data_d = acc_resp_data_i;
                        state_d    = ST_RESULT;
                    end else begin
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (acc_resp_valid_i) begin
                    res_data_d = acc_resp_data_i;
                    state_d    = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (x_result_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ent_valid_q <= '0;
            ent_cmt_q   <= '0;
            ent_kill_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_id_q[i]    <= '0;
                ent_instr_q[i] <= '0;
                ent_rs0_q[i]   <= '0;
                ent_rs1_q[i]   <= '0;
`ifdef X_COPRO_RS3_EN
                ent_rs2_q[i]   <= '0;
`endif
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            op_id_q    <= '0;
            op_instr_q <= '0;
            op_rs0_q   <= '0;
            op_rs1_q   <= '0;
`ifdef X_COPRO_RS3_EN
            op_rs2_q   <= '0;
`endif
            res_data_q <= '0;
        end else begin
            ent_valid_q <= ent_valid_d;
            ent_cmt_q   <= ent_cmt_d;
            ent_kill_q  <= ent_kill_d;
            ent_id_q    <= ent_id_d;
            ent_instr_q <= ent_instr_d;
            ent_rs0_q   <= ent_rs0_d;
            ent_rs1_q   <= ent_rs1_d;
`ifdef X_COPRO_RS3_EN
            ent_rs2_q   <= ent_rs2_d;
`endif
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            op_id_q    <= op_id_d;
            op_instr_q <= op_instr_d;
            op_rs0_q   <= op_rs0_d;
            op_rs1_q   <= op_rs1_d;
`ifdef X_COPRO_RS3_EN
            op_rs2_q   <= op_rs2_d;
`endif
            res_data_q <= res_data_d;
        end
    end

    assign x_issue_ready_o          = issue_ready;
    assign x_issue_resp_accept_o    = alloc;
    assign x_issue_resp_writeback_o = alloc;
    assign x_issue_resp_loadstore_o = 1'b0;

    assign acc_valid_o = (state_q == ST_EXEC);
    assign acc_instr_o = op_instr_q;
`ifdef X_COPRO_RS3_EN
    assign acc_rs_o    = {op_rs2_q, op_rs1_q, op_rs0_q};
`else
    assign acc_rs_o    = {32'h0, op_rs1_q, op_rs0_q};
`endif

    assign x_result_valid_o = (state_q == ST_RESULT);
    assign x_result_id_o    = op_id_q;
    assign x_result_data_o  = res_data_q;
    assign x_result_rd_o    = op_instr_q[11:7];
    assign x_result_we_o    = |op_instr_q[11:7];

    assign busy_o = (count_q != '0) | (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_x_copro_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_x_copro_adapter
// Brief    : Directed self-checking bench for the XIF coprocessor adapter.
// Revision : 1.0
// ============================================================================
module tb_cv32e40p_x_copro_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        x_issue_valid_i;
    logic        x_issue_ready_o;
    logic [31:0] x_issue_req_instr_i;
    logic [3:0]  x_issue_req_id_i;
    logic [95:0] x_issue_req_rs_i;
    logic [2:0]  x_issue_req_rs_valid_i;
    logic        x_issue_resp_accept_o;
    logic        x_issue_resp_writeback_o;
    logic        x_issue_resp_loadstore_o;
    logic        x_commit_valid_i;
    logic [3:0]  x_commit_id_i;
    logic        x_commit_kill_i;
    logic        acc_valid_o;
    logic        acc_ready_i;
    logic [31:0] acc_instr_o;
    logic [95:0] acc_rs_o;
    logic        acc_resp_valid_i;
    logic [31:0] acc_resp_data_i;
    logic        x_result_valid_o;
    logic        x_result_ready_i;
    logic [3:0]  x_result_id_o;
    logic [31:0] x_result_data_o;
    logic [4:0]  x_result_rd_o;
    logic        x_result_we_o;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ids[$];

    always #5 clk_i = ~clk_i;

    cv32e40p_x_copro_adapter #(
        .DEPTH    (4),
        .ID_WIDTH (4),
        .OPCODE   (7'h0B)
    ) dut (
        .clk_i                    (clk_i),
        .rst_ni                   (rst_ni),
        .x_issue_valid_i          (x_issue_valid_i),
        .x_issue_ready_o          (x_issue_ready_o),
        .x_issue_req_instr_i      (x_issue_req_instr_i),
        .x_issue_req_id_i         (x_issue_req_id_i),
        .x_issue_req_rs_i         (x_issue_req_rs_i),
        .x_issue_req_rs_valid_i   (x_issue_req_rs_valid_i),
        .x_issue_resp_accept_o    (x_issue_resp_accept_o),
        .x_issue_resp_writeback_o (x_issue_resp_writeback_o),
        .x_issue_resp_loadstore_o (x_issue_resp_loadstore_o),
        .x_commit_valid_i         (x_commit_valid_i),
        .x_commit_id_i            (x_commit_id_i),
        .x_commit_kill_i          (x_commit_kill_i),
        .acc_valid_o              (acc_valid_o),
        .acc_ready_i              (acc_ready_i),
        .acc_instr_o              (acc_instr_o),
        .acc_rs_o                 (acc_rs_o),
        .acc_resp_valid_i         (acc_resp_valid_i),
        .acc_resp_data_i          (acc_resp_data_i),
        .x_result_valid_o         (x_result_valid_o),
        .x_result_ready_i         (x_result_ready_i),
        .x_result_id_o            (x_result_id_o),
        .x_result_data_o          (x_result_data_o),
        .x_result_rd_o            (x_result_rd_o),
        .x_result_we_o            (x_result_we_o),
        .busy_o                   (busy_o)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Custom-0 instruction whose rd is id+1
    function automatic logic [31:0] mk_instr(input logic [3:0] id);
        logic [4:0] rd;
        rd = 5'(id) + 5'd1;
        return {20'h00000, rd, 7'h0B};
    endfunction

    task automatic set_issue(input logic [3:0] id);
        x_issue_valid_i     = 1'b1;
        x_issue_req_id_i    = id;
        x_issue_req_instr_i = mk_instr(id);
        x_issue_req_rs_i    = {32'h3300 + 32'(id), 32'h2000 + 32'(id), 32'h1000 + 32'(id)};
    endtask

    task automatic set_commit(input logic [3:0] id, input logic kill);
        x_commit_valid_i = 1'b1;
        x_commit_id_i    = id;
        x_commit_kill_i  = kill;
    endtask

    task automatic clear_inputs();
        x_issue_valid_i  = 1'b0;
        x_commit_valid_i = 1'b0;
        x_commit_kill_i  = 1'b0;
        acc_ready_i      = 1'b0;
        acc_resp_valid_i = 1'b0;
        x_result_ready_i = 1'b0;
    endtask

    // Accelerator answers in the handshake cycle with rs0+0x100; core always ready
    task automatic run_results(input int n_exp, input int max_cyc);
        int got  = 0;
        int accs = 0;
        x_result_ready_i = 1'b1;
        for (int c = 0; c < max_cyc && got < n_exp; c++) begin
            tick();
            acc_ready_i      = 1'b0;
            acc_resp_valid_i = 1'b0;
            if (acc_valid_o) begin
                acc_ready_i      = 1'b1;
                acc_resp_valid_i = 1'b1;
                acc_resp_data_i  = acc_rs_o[31:0] + 32'h100;
                accs++;
            end
            if (x_result_valid_o) begin
                chk("res_id",   96'(x_result_id_o),   96'(exp_ids[got]));
                chk("res_data", 96'(x_result_data_o), 96'(32'h1100 + exp_ids[got]));
                chk("res_rd",   96'(x_result_rd_o),   96'(exp_ids[got] + 1));
                chk("res_we",   96'(x_result_we_o),   96'(1));
                got++;
            end
        end
        chk("res_count", 96'(got), 96'(n_exp));
        chk("acc_count", 96'(accs), 96'(n_exp));
        tick();
        clear_inputs();
        chk("busy_after_run", 96'(busy_o), 96'(0));
        exp_ids.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] exp_rs;
        logic        seen;

        rst_ni                 = 1'b0;
        x_issue_req_instr_i    = '0;
        x_issue_req_id_i       = '0;
        x_issue_req_rs_i       = '0;
        x_issue_req_rs_valid_i = 3'b111;
        x_commit_id_i          = '0;
        acc_resp_data_i        = '0;
        clear_inputs();
        repeat (3) tick();
        rst_ni = 1'b1;

        // Reset state
        chk("rst_ready",    96'(x_issue_ready_o),          96'(1));
        chk("rst_accept",   96'(x_issue_resp_accept_o),    96'(0));
        chk("rst_wb",       96'(x_issue_resp_writeback_o), 96'(0));
        chk("rst_acc_vld",  96'(acc_valid_o),              96'(0));
        chk("rst_acc_ins",  96'(acc_instr_o),              96'(0));
        chk("rst_acc_rs",   acc_rs_o,                      96'(0));
        chk("rst_res_vld",  96'(x_result_valid_o),         96'(0));
        chk("rst_res_id",   96'(x_result_id_o),            96'(0));
        chk("rst_res_data", 96'(x_result_data_o),          96'(0));
        chk("rst_res_we",   96'(x_result_we_o),            96'(0));
        chk("rst_busy",     96'(busy_o),                   96'(0));

        x_issue_req_rs_valid_i = 3'b011;
        #1;
`ifdef X_COPRO_RS3_EN
        chk("ready_rs2_missing", 96'(x_issue_ready_o), 96'(0));
`else
        chk("ready_rs2_missing", 96'(x_issue_ready_o), 96'(1));
`endif
        x_issue_req_rs_valid_i = 3'b111;

        // Single op: issue+commit in cycle N, result valid in N+3
        tick();
        set_issue(4'd3);
        x_issue_req_instr_i = 32'h0020_858B;
        set_commit(4'd3, 1'b0);
        #1;
        chk("t1_accept", 96'(x_issue_resp_accept_o),    96'(1));
        chk("t1_wb",     96'(x_issue_resp_writeback_o), 96'(1));
        chk("t1_ls",     96'(x_issue_resp_loadstore_o), 96'(0));
        tick();
        clear_inputs();
        #1;
        chk("t1_n1_busy",    96'(busy_o),           96'(1));
        chk("t1_n1_acc_vld", 96'(acc_valid_o),      96'(0));
        chk("t1_n1_res_vld", 96'(x_result_valid_o), 96'(0));
        tick();
`ifdef X_COPRO_RS3_EN
        exp_rs = {32'h3303, 32'h2003, 32'h1003};
`else
        exp_rs = {32'h0, 32'h2003, 32'h1003};
`endif
        chk("t1_n2_acc_vld", 96'(acc_valid_o), 96'(1));
        chk("t1_n2_acc_ins", 96'(acc_instr_o), 96'(32'h0020_858B));
        chk("t1_n2_acc_rs",  acc_rs_o,         exp_rs);
        acc_ready_i      = 1'b1;
        acc_resp_valid_i = 1'b1;
        acc_resp_data_i  = 32'hCAFE;
        tick();
        clear_inputs();
        chk("t1_n3_res_vld",  96'(x_result_valid_o), 96'(1));
        chk("t1_n3_res_id",   96'(x_result_id_o),    96'(3));
        chk("t1_n3_res_rd",   96'(x_result_rd_o),    96'(11));
        chk("t1_n3_res_we",   96'(x_result_we_o),    96'(1));
        chk("t1_n3_res_data", 96'(x_result_data_o),  96'(32'hCAFE));
        x_result_ready_i = 1'b1;
        tick();
        clear_inputs();
        chk("t1_done_res_vld", 96'(x_result_valid_o), 96'(0));
        chk("t1_done_busy",    96'(busy_o),           96'(0));

        // Foreign opcode is rejected and allocates nothing
        x_issue_valid_i     = 1'b1;
        x_issue_req_id_i    = 4'd7;
        x_issue_req_instr_i = 32'h00B5_0533;
        #1;
        chk("t2_accept", 96'(x_issue_resp_accept_o),    96'(0));
        chk("t2_wb",     96'(x_issue_resp_writeback_o), 96'(0));
        tick();
        clear_inputs();
        chk("t2_busy", 96'(busy_o), 96'(0));
        tick();
        chk("t2_acc_vld", 96'(acc_valid_o), 96'(0));

        // Fill the buffer, check back-pressure, then drain in order
        for (int k = 0; k < 4; k++) begin
            set_issue(4'(k));
            #1;
            chk("t3_fill_accept", 96'(x_issue_resp_accept_o), 96'(1));
            tick();
        end
        set_issue(4'd4);
        set_commit(4'd0, 1'b0);
        #1;
        chk("t3_full_ready",  96'(x_issue_ready_o),       96'(0));
        chk("t3_full_accept", 96'(x_issue_resp_accept_o), 96'(0));
        tick();
        clear_inputs();
        #1;
        chk("t3_retire_ready", 96'(x_issue_ready_o), 96'(0));
        tick();
        chk("t3_after_ready", 96'(x_issue_ready_o), 96'(1));
        set_commit(4'd1, 1'b0);
        tick();
        set_commit(4'd2, 1'b0);
        tick();
        set_commit(4'd3, 1'b0);
        tick();
        clear_inputs();
        for (int k = 0; k < 4; k++) exp_ids.push_back(k);
        run_results(4, 60);

        // Killed entry never executes
        set_issue(4'd5);
        tick();
        set_issue(4'd6);
        set_commit(4'd5, 1'b1);
        #1;
        chk("t4_accept6", 96'(x_issue_resp_accept_o), 96'(1));
        tick();
        x_issue_valid_i = 1'b0;
        set_commit(4'd6, 1'b0);
        tick();
        clear_inputs();
        exp_ids.push_back(6);
        run_results(1, 30);

        // Result back-pressure holds the result and blocks the next op
        set_issue(4'd8);
        set_commit(4'd8, 1'b0);
        tick();
        set_issue(4'd9);
        set_commit(4'd9, 1'b0);
        tick();
        clear_inputs();
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (acc_valid_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_acc_seen", 96'(seen),        96'(1));
        chk("t5_acc_ins8", 96'(acc_instr_o), 96'(mk_instr(4'd8)));
        acc_ready_i      = 1'b1;
        acc_resp_valid_i = 1'b1;
        acc_resp_data_i  = 32'hBEEF;
        tick();
        clear_inputs();
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_vld",  96'(x_result_valid_o), 96'(1));
            chk("t5_hold_id",   96'(x_result_id_o),    96'(8));
            chk("t5_hold_data", 96'(x_result_data_o),  96'(32'hBEEF));
            chk("t5_hold_acc",  96'(acc_valid_o),      96'(0));
            tick();
        end
        x_result_ready_i = 1'b1;
        tick();
        x_result_ready_i = 1'b0;
        chk("t5_idle_res_vld", 96'(x_result_valid_o), 96'(0));
        chk("t5_idle_acc_vld", 96'(acc_valid_o),      96'(0));
        chk("t5_idle_busy",    96'(busy_o),           96'(1));
        tick();
        chk("t5_next_acc_vld", 96'(acc_valid_o), 96'(1));
        chk("t5_next_acc_ins", 96'(acc_instr_o), 96'(mk_instr(4'd9)));
        exp_ids.push_back(9);
        run_results(1, 30);

        // Reset while waiting on the accelerator with two entries buffered
        for (int k = 10; k < 13; k++) begin
            set_issue(4'(k));
            set_commit(4'(k), 1'b0);
            tick();
        end
        clear_inputs();
        chk("t6_acc_vld",  96'(acc_valid_o), 96'(1));
        chk("t6_acc_ins",  96'(acc_instr_o), 96'(mk_instr(4'd10)));
        acc_ready_i = 1'b1;
        tick();
        acc_ready_i = 1'b0;
        chk("t6_wait_acc",  96'(acc_valid_o),      96'(0));
        chk("t6_wait_res",  96'(x_result_valid_o), 96'(0));
        chk("t6_wait_busy", 96'(busy_o),           96'(1));
        rst_ni = 1'b0;
        tick();
        rst_ni           = 1'b1;
        acc_resp_valid_i = 1'b1;
        acc_resp_data_i  = 32'hDEAD;
        #1;
        chk("t6_rst_ready",   96'(x_issue_ready_o),  96'(1));
        chk("t6_rst_acc_vld", 96'(acc_valid_o),      96'(0));
        chk("t6_rst_acc_ins", 96'(acc_instr_o),      96'(0));
        chk("t6_rst_res_vld", 96'(x_result_valid_o), 96'(0));
        chk("t6_rst_res_id",  96'(x_result_id_o),    96'(0));
        chk("t6_rst_res_we",  96'(x_result_we_o),    96'(0));
        chk("t6_rst_busy",    96'(busy_o),           96'(0));
        tick();
        acc_resp_valid_i = 1'b0;
        chk("t6_late_res_vld",  96'(x_result_valid_o), 96'(0));
        chk("t6_late_res_data", 96'(x_result_data_o),  96'(0));
        chk("t6_late_busy",     96'(busy_o),           96'(0));
        tick();
        chk("t6_late_acc_vld", 96'(acc_valid_o), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
